// File: rtl/mbe_csa_pkg.sv
// rtl/mbe_csa_pkg.sv - shared types for the sequential Booth/CSA multiplier
// FSM state, one-hot Booth digit and partial-product count helper.
package mbe_csa_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCUM   = 2'd1,
      RESOLVE = 2'd2,
      DONE    = 2'd3
   } state_t;

   typedef struct packed {
      logic neg;
      logic x1;
      logic x2;
   } booth_t;

   function automatic int num_pp(input int n);
      return n / 2;
   endfunction

endpackage

// File: rtl/mbe_csa_seq_mul_if.sv
// rtl/mbe_csa_seq_mul_if.sv - operand/result handshake bundle for mbe_csa_seq_mul
// in_acc_clr exists only when MBE_MAC_ACC_EN is defined.
interface mbe_csa_seq_mul_if #(
   parameter int N = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [N-1:0]     in_a;
   logic [N-1:0]     in_b;
`ifdef MBE_MAC_ACC_EN
   logic             in_acc_clr;
`endif
   logic             out_valid;
   logic             out_ready;
   logic [2*N-1:0]   out_p;

   modport master (
`ifdef MBE_MAC_ACC_EN
      output in_acc_clr,
`endif
      output in_valid, in_a, in_b, out_ready,
      input  in_ready, out_valid, out_p
   );

   modport slave (
`ifdef MBE_MAC_ACC_EN
      input  in_acc_clr,
`endif
      input  in_valid, in_a, in_b, out_ready,
      output in_ready, out_valid, out_p
   );
endinterface

// File: rtl/csa.sv
// rtl/csa.sv - W-bit 3:2 carry-save compressor
// Carry output is unshifted; the caller aligns it.
module csa #(
   parameter int W = 16
) (
   input  logic [W-1:0] x,
   input  logic [W-1:0] y,
   input  logic [W-1:0] z,
   output logic [W-1:0] s,
   output logic [W-1:0] c
);
   assign s = x ^ y ^ z;
   assign c = (x & y) | (x & z) | (y & z);
endmodule

// File: rtl/mbe_pp_gen.sv
// rtl/mbe_pp_gen.sv - radix-4 Booth encoder and partial-product generator
// Produces (d_k * a) sign-extended to 2N bits and shifted left by 2k.
module mbe_pp_gen
   import mbe_csa_pkg::*;
#(
   parameter int N  = 8,
   parameter int KW = 2
) (
   input  logic [2:0]     trip,
   input  logic [N-1:0]   a,
   input  logic [KW-1:0]  k,
   output logic [2*N-1:0] pp
);
   booth_t         d;
   logic [2*N-1:0] a_ext;
   logic [2*N-1:0] mag;
   logic [2*N-1:0] spp;

   always_comb begin
      d = '0;
      unique case (trip)
         3'b001, 3'b010: d.x1 = 1'b1;
         3'b011:         d.x2 = 1'b1;
         3'b100:         begin d.neg = 1'b1; d.x2 = 1'b1; end
         3'b101, 3'b110: begin d.neg = 1'b1; d.x1 = 1'b1; end
         default:        ;
      endcase
   end

   assign a_ext = {{N{a[N-1]}}, a};
   assign mag   = d.x2 ? (a_ext << 1) : (d.x1 ? a_ext : '0);
   assign spp   = d.neg ? (~mag + 1'b1) : mag;
   assign pp    = spp << {k, 1'b0};
endmodule

// File: rtl/mbe_csa_seq_mul.sv
// rtl/mbe_csa_seq_mul.sv - sequential radix-4 Booth multiplier on one shared CSA
// Define MBE_MAC_ACC_EN to add the acc_r accumulator and in_acc_clr.
module mbe_csa_seq_mul
   import mbe_csa_pkg::*;
#(
   parameter int N = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   mbe_csa_seq_mul_if.slave bus,
   output logic             busy
);
   localparam int NUM_PP = num_pp(N);
   localparam int KW     = (NUM_PP > 1) ? $clog2(NUM_PP) : 1;
   localparam int W      = 2 * N;

   state_t        state_q, state_d;
   logic [N-1:0]  a_r, b_r;
   logic [KW-1:0] k_r;
   logic [W-1:0]  sum_r, carry_r, res_r;
   logic [W-1:0]  init, pp, csa_s, csa_c, final_sum;
   logic [2:0]    trip;
   logic          accept, last_pp;

`ifdef MBE_MAC_ACC_EN
   logic [W-1:0]  acc_r;
   assign init = bus.in_acc_clr ? '0 : acc_r;
`else
   assign init = '0;
`endif

   assign accept    = (state_q == IDLE) && bus.in_valid;
   assign last_pp   = (k_r == KW'(NUM_PP - 1));
   // b_r[-1] = 0 is supplied by the appended zero below the LSB
   assign trip      = 3'({b_r, 1'b0} >> {k_r, 1'b0});
   assign final_sum = sum_r + carry_r;
   assign bus.out_p = res_r;

   mbe_pp_gen #(
      .N  (N),
      .KW (KW)
   ) u_pp_gen (
      .trip (trip),
      .a    (a_r),
      .k    (k_r),
      .pp   (pp)
   );

   csa #(
      .W (W)
   ) u_csa (
      .x (sum_r),
      .y (carry_r),
      .z (pp),
      .s (csa_s),
      .c (csa_c)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d       = state_q;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      busy          = 1'b1;
      unique case (state_q)
         IDLE: begin
            bus.in_ready = 1'b1;
            busy         = 1'b0;
            if (bus.in_valid) state_d = ACCUM;
         end
         ACCUM:   if (last_pp) state_d = RESOLVE;
         RESOLVE: state_d = DONE;
         DONE: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_r     <= '0;
         b_r     <= '0;
         k_r     <= '0;
         sum_r   <= '0;
         carry_r <= '0;
         res_r   <= '0;
`ifdef MBE_MAC_ACC_EN
         acc_r   <= '0;
`endif
      end else begin
         unique case (state_q)
            IDLE: begin
               if (accept) begin
                  a_r     <= bus.in_a;
                  b_r     <= bus.in_b;
                  k_r     <= '0;
                  sum_r   <= init;
                  carry_r <= '0;
               end
            end
            ACCUM: begin
               sum_r   <= csa_s;
               // carry MSB falls off: arithmetic is modulo 2^(2N)
               carry_r <= {csa_c[W-2:0], 1'b0};
               k_r     <= k_r + KW'(1);
            end
            RESOLVE: begin
               res_r <= final_sum;
`ifdef MBE_MAC_ACC_EN
               acc_r <= final_sum;
`endif
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_mbe_csa_seq_mul.sv
// tb/tb_mbe_csa_seq_mul.sv - self-checking bench for mbe_csa_seq_mul (N=8)
// MAC sequences are included when MBE_MAC_ACC_EN is defined.
module tb_mbe_csa_seq_mul;
   logic clk;
   logic rst_n;
   logic busy;

   int n_cmp = 0;
   int n_bad = 0;
   logic [15:0] model_acc = 16'h0;

   mbe_csa_seq_mul_if #(.N(8)) bus ();

   mbe_csa_seq_mul #(.N(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus),
      .busy  (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  a;
      logic [7:0]  b;
      logic [15:0] p;
   } vec_t;

   vec_t tbl [7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic timeout_fail(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got timeout, required event within bound", name);
   endtask

   task automatic set_clr(input logic c);
`ifdef MBE_MAC_ACC_EN
      bus.in_acc_clr = c;
`else
      if (c) bus.in_a = bus.in_a;
`endif
   endtask

   function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b, input logic clr);
      int pa, pb;
      logic [15:0] base;
      pa = $signed(a);
      pb = $signed(b);
      base = clr ? 16'h0 : model_acc;
`ifndef MBE_MAC_ACC_EN
      base = 16'h0;
`endif
      return 16'(pa * pb + int'(base));
   endfunction

   // Offer one operand pair, then return the result and the accept-to-valid latency.
   task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic clr,
                         output logic [15:0] p, output int lat);
      int guard = 0;
      while (!bus.in_ready && guard < 50) begin @(negedge clk); guard++; end
      if (!bus.in_ready) timeout_fail("in_ready_wait");
      bus.in_valid = 1'b1;
      bus.in_a     = a;
      bus.in_b     = b;
      set_clr(clr);
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_a     = 8'($urandom);
      bus.in_b     = 8'($urandom);
      lat = 0;
      while (!bus.out_valid && lat < 50) begin @(negedge clk); lat++; end
      if (!bus.out_valid) timeout_fail("out_valid_wait");
      p = bus.out_p;
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.out_ready = 1'b0;
   endtask

   task automatic op_check(input logic [7:0] a, input logic [7:0] b, input logic clr,
                           input logic [15:0] exp, input string name);
      logic [15:0] p;
      int lat;
      run_op(a, b, clr, p, lat);
      check({name, "_p"}, 32'(p), 32'(exp));
      check({name, "_lat"}, 32'(lat), 32'd5);
      check({name, "_rdy_after"}, 32'(bus.in_ready), 32'd1);
      model_acc = exp;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, required finish before 200us");
      $fatal(1);
   end

   initial begin
      logic [7:0]  ra, rb;
      logic        rc;
      logic [15:0] e;
      int          guard;

      tbl[0] = '{8'd7,   8'hFD, 16'hFFEB};
      tbl[1] = '{8'h80,  8'h80, 16'h4000};
      tbl[2] = '{8'h00,  8'hB3, 16'h0000};
      tbl[3] = '{8'hFF,  8'hFF, 16'h0001};
      tbl[4] = '{8'h7F,  8'h80, 16'hC080};
      tbl[5] = '{8'h80,  8'h7F, 16'hC080};
      tbl[6] = '{8'd5,   8'd6,  16'h001E};

      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_a      = 8'h0;
      bus.in_b      = 8'h0;
      bus.out_ready = 1'b0;
      set_clr(1'b0);
      #1;
      check("rst_in_ready",  32'(bus.in_ready),  32'd1);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_busy",      32'(busy),          32'd0);
      check("rst_out_p",     32'(bus.out_p),     32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 7; i++)
         op_check(tbl[i].a, tbl[i].b, 1'b1, tbl[i].p, $sformatf("tbl%0d", i));

      // Backpressure: result held, in_ready low, in_valid pulses ignored.
      bus.in_valid = 1'b1;
      bus.in_a     = 8'd7;
      bus.in_b     = 8'hFD;
      set_clr(1'b1);
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      guard = 0;
      while (!bus.out_valid && guard < 50) begin @(negedge clk); guard++; end
      if (!bus.out_valid) timeout_fail("hold_valid_wait");
      for (int i = 0; i < 10; i++) begin
         check($sformatf("hold%0d_p", i),     32'(bus.out_p),     32'h0000FFEB);
         check($sformatf("hold%0d_valid", i), 32'(bus.out_valid), 32'd1);
         check($sformatf("hold%0d_ready", i), 32'(bus.in_ready),  32'd0);
         bus.in_valid = i[0];
         bus.in_a     = 8'($urandom);
         bus.in_b     = 8'($urandom);
         @(negedge clk);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.out_ready = 1'b0;
      check("release_valid", 32'(bus.out_valid), 32'd0);
      check("release_ready", 32'(bus.in_ready),  32'd1);
      check("release_busy",  32'(busy),          32'd0);
      model_acc = 16'hFFEB;
      op_check(8'd3, 8'd4, 1'b1, 16'h000C, "post_hold");

      // Reset asserted during ACCUM aborts the operation.
      bus.in_valid = 1'b1;
      bus.in_a     = 8'd100;
      bus.in_b     = 8'd100;
      set_clr(1'b0);
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      @(negedge clk);
      check("mid_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check("abort_in_ready",  32'(bus.in_ready),  32'd1);
      check("abort_out_valid", 32'(bus.out_valid), 32'd0);
      check("abort_busy",      32'(busy),          32'd0);
      check("abort_out_p",     32'(bus.out_p),     32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      model_acc = 16'h0;
      @(negedge clk);
      op_check(8'd5, 8'd6, 1'b0, 16'h001E, "after_abort");

`ifdef MBE_MAC_ACC_EN
      op_check(8'd3,   8'd4,   1'b1, 16'h000C, "mac_clr");
      op_check(8'd5,   8'd6,   1'b0, 16'h002A, "mac_acc");
      op_check(8'h7F,  8'h7F,  1'b1, 16'h3F01, "mac127_1");
      op_check(8'h7F,  8'h7F,  1'b0, 16'h7E02, "mac127_2");
      op_check(8'h7F,  8'h7F,  1'b0, 16'hBD03, "mac127_3");
`endif

      for (int i = 0; i < 40; i++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         rc = ($urandom_range(0, 3) == 0);
         e  = model(ra, rb, rc);
         op_check(ra, rb, rc, e, $sformatf("rnd%0d", i));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/mbe_csa_seq_mul.md
# mbe_csa_seq_mul

Sequential radix-4 Modified-Booth signed multiplier (optional multiply-accumulate) built around one shared 2N-bit 3:2 carry-save compressor. It accepts one operand pair per valid/ready handshake and issues one Booth partial product per cycle into the compressor, keeping sum/carry redundant. It resolves the result with a single carry-propagate add and returns it on a valid/ready output. It is the sequencing controller that time-shares the CSA datapath instead of building a full CSA tree.

## Interface
- N, 8: operand width in bits; even, at least 4. Result width is 2N.
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand pair offered
- in_ready  output  1  block can accept an operand pair
- in_a  input  N  signed multiplicand
- in_b  input  N  signed multiplier (Booth-recoded)
- in_acc_clr  input  1  present only with MBE_MAC_ACC_EN; sampled at accept
- out_valid  output  1  result available
- out_ready  input  1  consumer takes the result
- out_p  output  2N  signed result, two's complement, modulo 2^(2N)
- busy  output  1  high in every state except IDLE

## Operation
- The FSM has four states: IDLE, ACCUM, RESOLVE, DONE.
- IDLE: in_ready=1. When in_valid is high, the operands are accepted.
  - a_r and b_r are registered.
  - Digit counter k=0.
  - sum_r = init. init is 0, or acc_r when the macro is set and in_acc_clr=0.
  - carry_r=0.
  - The next state is ACCUM.
- ACCUM: one Booth digit per cycle, k=0..N/2-1.
  - Digit d_k ∈ {-2,-1,0,+1,+2} comes from b_r[2k+1], b_r[2k], b_r[2k-1], with b_r[-1]=0.
  - pp_k = (d_k·a_r) sign-extended to 2N bits and shifted left by 2k, truncated to 2N bits.
  - The compressor computes (s,c) = CSA(sum_r, carry_r, pp_k).
  - sum_r ← s. carry_r ← {c[2N-2:0],1'b0}. The carry MSB is discarded (mod 2^(2N)).
  - After k=N/2-1, the next state is RESOLVE.
- RESOLVE: res_r ← sum_r + carry_r, mod 2^(2N). With the macro, acc_r ← the same value. The next state is DONE.
- DONE: out_valid=1 and out_p=res_r are held stable until out_ready=1. Then the FSM returns to IDLE.
- in_valid outside IDLE is ignored; in_ready is 0 there. out_ready outside DONE is ignored.
- Arithmetic is exact for all N-bit signed pairs, including (-2^(N-1))², which fits in 2N signed bits. Accumulation wraps modulo 2^(2N) with no saturation and no overflow flag.

## Timing
- Reset values:
  - State IDLE, in_ready=1.
  - out_valid=0, busy=0, out_p=0.
  - sum_r, carry_r and res_r are 0. acc_r is 0 with the macro.
- Accept at edge T. ACCUM runs on edges T+1..T+N/2. RESOLVE runs on edge T+N/2+1. out_valid rises after edge T+N/2+1 (after T+5 for N=8).
- Output accept at edge U. The FSM is back in IDLE after U, and in_ready=1 from the cycle after U. With continuous valid/ready, the minimum initiation interval is N/2+3 cycles.
- in_ready is combinational from state only. There is no combinational path from in_valid or out_ready to any output.
- Reset asserted mid-operation aborts immediately. No out_valid is produced for the aborted operation, and acc_r is cleared.

## Configuration
- MBE_MAC_ACC_EN defined:
  - Adds the in_acc_clr port and the 2N-bit acc_r register.
  - The CSA initial sum is acc_r unless in_acc_clr=1 at accept, in which case it is 0.
  - Every result is written back to acc_r.
- MBE_MAC_ACC_EN undefined: pure multiplier. The initial sum is always 0, and there is no acc_r and no in_acc_clr.

## Structure
- Shared package mbe_csa_pkg holds:
  - The state enum (IDLE/ACCUM/RESOLVE/DONE).
  - The Booth-digit typedef (3-bit signed, or one-hot neg/x1/x2).
  - The NUM_PP=N/2 constant function.
- One sub-module, mbe_pp_gen: Booth encoder plus partial-product generator (b triplet, a_r, k → 2N-bit pp_k).
- The compressor is an instance of the team's existing 2N-bit 3:2 csa. The FSM, counter, registers and final adder live in the top.

## Test plan
- N=8, a=7, b=-3 → out_p=16'hFFEB, with out_valid exactly 5 cycles after accept.
- a=-128, b=-128 → 16'h4000. a=0, b=-77 → 16'h0000. a=-1, b=-1 → 16'h0001.
- Hold out_ready=0 for 10 cycles → out_p stable, in_ready=0, and in_valid pulses are ignored. Release → one transfer, then in_ready=1.
- Assert rst_n low during ACCUM → all outputs at reset values. A new op of 5×6 then yields 16'h001E.
- MBE_MAC_ACC_EN: 3×4 with clr=1 → 16'h000C. Then 5×6 with clr=0 → 16'h002A.
- MBE_MAC_ACC_EN, 127×127 three times (clr only on the first) → 16'h3F01, then 16'h7E02, then 16'hBD03 (wrap).
